tapped_window_fifo: RTL
=======================

// Module: tapped_window_fifo
// PURPOSE
//  Enable-gated tapped shift FIFO for the census/stereo datapath. Advances only on in_valid.
//  Tracks per-stage validity and reports a full-window flag so the census windowing logic
//  knows when every tap holds live data. A flush input restarts a window at row/frame
//  boundaries without waiting DEPTH cycles.
// PARAMETERS
//  WIDTH  1  bits per word
//  DEPTH  1  number of stages (>=1)
//  CW     $clog2(DEPTH+1)  width of fill_count; derived, not overridden
// PORTS
//  clk           in   1            clock; all state updates on posedge
//  rst           in   1            synchronous reset, active-high
//  in_valid      in   1            shift enable; inp accepted this cycle
//  inp           in   WIDTH        word entering stage 0
//  flush         in   1            invalidate all stages (data regs retained)
//  taps          out  WIDTH*DEPTH  all stages; MS word = stage 0 (newest), LS word = stage DEPTH-1 (oldest)
//  tap_valid     out  DEPTH        per-stage valid; bit DEPTH-1 = stage 0, bit 0 = stage DEPTH-1
//  outp          out  WIDTH        stage DEPTH-1 (== LS word of taps)
//  out_valid     out  1            valid of stage DEPTH-1 (== tap_valid[0])
//  window_valid  out  1            registered; 1 iff all DEPTH stages valid
//  fill_count    out  CW           number of valid stages, 0..DEPTH, saturating
// BEHAVIOUR
//  - Reset: data regs, tap_valid, out_valid, window_valid, fill_count all 0; taps/outp read 0.
//  - Shift (in_valid=1, flush=0): stage0<=inp, stage[i+1]<=stage[i]; valid bits shift the same
//    way with 1 entering stage 0. Latency inp -> stage k is k+1 accepted cycles.
//  - Hold (in_valid=0, flush=0): data and valid bits unchanged. There are no gaps;
//    idle cycles do not age data.
//  - fill_count: +1 per accepted word while < DEPTH, saturates at DEPTH; never decrements
//    except on flush/rst. Invariant: fill_count == popcount(tap_valid).
//  - window_valid = (fill_count == DEPTH), registered alongside state (same-cycle as tap_valid).
//  - Flush alone: all valid bits 0, fill_count 0, window_valid 0 next cycle; data regs untouched.
//  - Flush + in_valid same cycle: flush applies first, then inp is accepted into stage 0.
//    Next cycle: tap_valid = only stage-0 bit set, fill_count = 1, window_valid = (DEPTH==1).
//  - Priority: rst > flush > in_valid.
//  - DEPTH==1: single stage; taps==outp; window_valid follows out_valid.
//  - Reset mid-operation: all state cleared next edge regardless of in_valid/flush.
//  - No overflow condition: the oldest word is discarded on each accepted shift when full.
// STRUCTURE
//  - Shared include (codebase common header): clog2 helper used to derive CW.
//    No typedefs are needed.
//  - One sub-module, dffe (WIDTH-param D flip-flop with sync reset + enable), placed in
//    the shared lib beside dff. Instantiate it DEPTH times in a generate loop for data.
//  - Valid shift register, fill counter and window flag live in this module as plain regs.
// TESTING
//  1. rst=1 2 cycles, WIDTH=8 DEPTH=4 -> taps=0, tap_valid=0, fill_count=0, window_valid=0.
//  2. in_valid=1 for inp=01,02,03,04 -> after 4th edge taps=32'h04030201, tap_valid=4'b1111,
//     fill_count=4, window_valid=1; after 3rd edge window_valid=0, fill_count=3.
//  3. In the full state of test 2, hold in_valid=0 for 5 cycles -> taps/valids/count unchanged.
//     Then inp=05 -> taps=32'h05040302, outp=02, fill_count stays 4.
//  4. Full window, pulse flush alone -> tap_valid=0, fill_count=0, window_valid=0, taps unchanged.
//     Flush+in_valid with inp=AA -> tap_valid=4'b1000, fill_count=1, taps MS byte=AA.
//  5. Assert rst while in_valid=1 and flush=1 mid-fill -> all outputs 0 next cycle.
//     Then feed 4 words -> window_valid on the 4th.
//  6. DEPTH=1 WIDTH=3: inp=5 with in_valid -> outp=5, out_valid=1, window_valid=1, fill_count=1.
//     Random in_valid/flush run checks the popcount(tap_valid)==fill_count invariant each cycle.

Source files
------------

// File: rtl/tapped_window_fifo_pkg.sv
// rtl/tapped_window_fifo_pkg.sv - shared helpers for the tapped window FIFO
package tapped_window_fifo_pkg;

  // Smallest w with 2**w >= n; used to size fill_count for 0..DEPTH.
  function automatic int clog2(input int n);
    int w;
    w = 0;
    while ((1 << w) < n) w++;
    return w;
  endfunction

endpackage

// File: rtl/tapped_window_fifo_if.sv
// rtl/tapped_window_fifo_if.sv - input stream and tap outputs of the tapped window FIFO
interface tapped_window_fifo_if
  import tapped_window_fifo_pkg::*;
#(
  parameter int WIDTH = 1,
  parameter int DEPTH = 1
);
  localparam int CW = clog2(DEPTH + 1);

  logic                   in_valid;
  logic [WIDTH-1:0]       inp;
  logic                   flush;
  logic [WIDTH*DEPTH-1:0] taps;
  logic [DEPTH-1:0]       tap_valid;
  logic [WIDTH-1:0]       outp;
  logic                   out_valid;
  logic                   window_valid;
  logic [CW-1:0]          fill_count;

  modport master (
    output in_valid, inp, flush,
    input  taps, tap_valid, outp, out_valid, window_valid, fill_count
  );

  modport slave (
    input  in_valid, inp, flush,
    output taps, tap_valid, outp, out_valid, window_valid, fill_count
  );
endinterface

// File: rtl/tapped_window_fifo_dffe.sv
// rtl/tapped_window_fifo_dffe.sv - WIDTH-bit D flip-flop with sync reset and enable
module tapped_window_fifo_dffe #(
  parameter int WIDTH = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);
  always_ff @(posedge clk) begin
    if (rst)     q <= '0;
    else if (en) q <= d;
  end
endmodule

// File: rtl/tapped_window_fifo.sv
// rtl/tapped_window_fifo.sv - enable-gated tapped shift FIFO with per-stage valid
// and full-window flag; flush clears validity only, data registers are kept.
module tapped_window_fifo
  import tapped_window_fifo_pkg::*;
#(
  parameter int WIDTH = 1,
  parameter int DEPTH = 1
) (
  input  logic                clk,
  input  logic                rst,
  tapped_window_fifo_if.slave bus
);
  localparam int CW = clog2(DEPTH + 1);

  logic [WIDTH-1:0] stage [DEPTH];
  logic [DEPTH-1:0] tv_q, tv_d;
  logic [CW-1:0]    fill_q, fill_d;
  logic             win_q;

  for (genvar i = 0; i < DEPTH; i++) begin : g_stage
    logic [WIDTH-1:0] d;
    if (i == 0) begin : g_head
      assign d = bus.inp;
    end else begin : g_body
      assign d = stage[i-1];
    end

    tapped_window_fifo_dffe #(.WIDTH(WIDTH)) u_dffe (
      .clk (clk),
      .rst (rst),
      .en  (bus.in_valid),
      .d   (d),
      .q   (stage[i])
    );

    // Stage 0 (newest) lands in the most significant word.
    assign bus.taps[WIDTH*(DEPTH-1-i) +: WIDTH] = stage[i];
  end

  // tv bit DEPTH-1 is stage 0, so a shift moves valids toward bit 0.
  always_comb begin
    tv_d   = tv_q;
    fill_d = fill_q;
    if (bus.flush) begin
      tv_d   = '0;
      fill_d = '0;
    end
    if (bus.in_valid) begin
      tv_d = (tv_d >> 1) | (DEPTH'(1) << (DEPTH - 1));
      if (fill_d < CW'(DEPTH)) fill_d = fill_d + CW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      tv_q   <= '0;
      fill_q <= '0;
      win_q  <= 1'b0;
    end else begin
      tv_q   <= tv_d;
      fill_q <= fill_d;
      win_q  <= (fill_d == CW'(DEPTH));
    end
  end

  assign bus.tap_valid    = tv_q;
  assign bus.outp         = stage[DEPTH-1];
  assign bus.out_valid    = tv_q[0];
  assign bus.window_valid = win_q;
  assign bus.fill_count   = fill_q;
endmodule
